// File: rtl/pwm_gen_pkg.sv
// Shared types for the emulator PWM source (pwm_gen_digital, pwm_deadtime).
// Dead-time logic is built only when PWM_GEN_DEADTIME_EN is defined.
package pwm_gen_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned DEAD_CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Turns the raw PWM level into out/out_n, keeping the rising side low for DEAD_CYCLES
// after every raw edge. Used by pwm_gen_digital only when PWM_GEN_DEADTIME_EN is defined.
module pwm_deadtime
    import pwm_gen_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic raw,
    output logic out,
    output logic out_n
);

    logic                  raw_q;
    logic [DEAD_CNT_W-1:0] dead_cnt;
    logic                  edge_c;

    // A raw edge starts a new both-low gap; zero dead time passes raw straight through.
    always_comb begin
        edge_c = (raw != raw_q) && (DEAD_CYCLES != 0);
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            raw_q    <= 1'b0;
            dead_cnt <= '0;
            out      <= 1'b0;
            out_n    <= 1'b0;
        end else begin
            raw_q <= raw;
            if (edge_c) begin
                dead_cnt <= DEAD_CNT_W'(DEAD_CYCLES - 1);
                out      <= 1'b0;
                out_n    <= 1'b0;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_CNT_W'(1);
                out      <= 1'b0;
                out_n    <= 1'b0;
            end else begin
                out   <= raw;
                out_n <= !raw;
            end
        end
    end

endmodule

// File: rtl/pwm_gen_digital.sv
// Period-counter PWM source with a glitch-free valid/ready config slot applied at wrap.
// Define PWM_GEN_DEADTIME_EN to insert dead time between out and out_n.
module pwm_gen_digital
    import pwm_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = CNT_W,
    parameter int unsigned DEFAULT_PERIOD = 100,
    parameter int unsigned DEFAULT_DUTY   = 50,
    parameter int unsigned DEAD_CYCLES    = 2
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] period_in,
    input  logic [CNT_WIDTH-1:0] duty_in,
    output logic                 out,
    output logic                 out_n,
    output logic                 cycle_start
);

    if (DEFAULT_PERIOD < 1 || DEAD_CYCLES >= (32'd1 << DEAD_CNT_W)) begin : g_param_check
        $error("pwm_gen_digital: DEFAULT_PERIOD must be >= 1 and DEAD_CYCLES must fit DEAD_CNT_W");
    end

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_act;
    logic [CNT_WIDTH-1:0] duty_act;
    logic [CNT_WIDTH-1:0] pend_period;
    logic [CNT_WIDTH-1:0] pend_duty;
    logic                 pend_valid;
    logic                 run_c;
    logic                 wrap_c;
    logic                 raw_c;
    logic                 xfer_c;
    logic                 apply_c;
    logic                 pend_nxt_c;
    logic [CNT_WIDTH-1:0] period_fix_c;

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counting only happens on cycles that stay in RUN; dropping en clears cnt at once.
    always_comb begin
        state_nxt    = state;
        run_c        = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    run_c = 1'b1;
                end
            end
        endcase
        wrap_c       = run_c && (cnt == period_act - CNT_WIDTH'(1));
        raw_c        = run_c && (cnt < duty_act);
        xfer_c       = cfg_valid && cfg_ready;
        apply_c      = pend_valid && (wrap_c || (state == IDLE));
        pend_nxt_c   = xfer_c || (pend_valid && !apply_c);
        period_fix_c = (period_in == '0) ? CNT_WIDTH'(1) : period_in;
    end

    // Apply reads the old slot contents, so a transfer on a wrap edge waits one more period.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            cnt         <= '0;
            period_act  <= CNT_WIDTH'(DEFAULT_PERIOD);
            duty_act    <= CNT_WIDTH'(DEFAULT_DUTY);
            pend_period <= '0;
            pend_duty   <= '0;
            pend_valid  <= 1'b0;
            cfg_ready   <= 1'b1;
            cycle_start <= 1'b0;
        end else begin
            cnt <= (run_c && !wrap_c) ? cnt + CNT_WIDTH'(1) : '0;
            if (apply_c) begin
                period_act <= pend_period;
                duty_act   <= pend_duty;
            end
            if (xfer_c) begin
                pend_period <= period_fix_c;
                pend_duty   <= duty_in;
            end
            pend_valid  <= pend_nxt_c;
            cfg_ready   <= !pend_nxt_c;
            cycle_start <= run_c && (cnt == '0);
        end
    end

`ifdef PWM_GEN_DEADTIME_EN
    pwm_deadtime #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk    (emu_clk),
        .rst    (emu_rst),
        .active (run_c),
        .raw    (raw_c),
        .out    (out),
        .out_n  (out_n)
    );
`else
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            out   <= 1'b0;
            out_n <= 1'b0;
        end else begin
            out   <= raw_c;
            out_n <= run_c && !raw_c;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen_digital.sv
// Directed bench for pwm_gen_digital (defaults period 10 / duty 5); the dead-time
// checks are compiled in when PWM_GEN_DEADTIME_EN is defined.
module tb_pwm_gen_digital;

    logic        emu_clk;
    logic        emu_rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] period_in;
    logic [15:0] duty_in;
    logic        out;
    logic        out_n;
    logic        cycle_start;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pwm_gen_digital #(
        .CNT_WIDTH      (16),
        .DEFAULT_PERIOD (10),
        .DEFAULT_DUTY   (5),
        .DEAD_CYCLES    (2)
    ) dut (
        .emu_clk     (emu_clk),
        .emu_rst     (emu_rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .out         (out),
        .out_n       (out_n),
        .cycle_start (cycle_start)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Step n edges; the output of each edge reflects counter phase (ph0+i) mod p.
    task automatic cyc(input string tag, input int p, input int d, input int ph0, input int n);
        int ph;
        for (int i = 0; i < n; i++) begin
            step();
            ph = (ph0 + i) % p;
`ifdef PWM_GEN_DEADTIME_EN
            chk({tag, ".overlap"}, out & out_n, 1'b0);
`else
            chk({tag, ".out"}, out, ph < d);
            chk({tag, ".out_n"}, out_n, !(ph < d));
`endif
            chk({tag, ".cs"}, cycle_start, ph == 0);
        end
    endtask

    task automatic send(input logic [15:0] p, input logic [15:0] d);
        cfg_valid = 1'b1;
        period_in = p;
        duty_in   = d;
    endtask

    initial begin
        emu_rst   = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        period_in = '0;
        duty_in   = '0;

        // Reset state
        step();
        step();
        chk("rst.out", out, 1'b0);
        chk("rst.out_n", out_n, 1'b0);
        chk("rst.cs", cycle_start, 1'b0);
        chk("rst.ready", cfg_ready, 1'b1);

        // 1: free run with defaults
        emu_rst = 1'b0;
        en      = 1'b1;
        step();
        chk("t1.enter.out", out, 1'b0);
        chk("t1.enter.cs", cycle_start, 1'b0);
        cyc("t1", 10, 5, 0, 20);
        chk("t1.ready", cfg_ready, 1'b1);

`ifdef PWM_GEN_DEADTIME_EN
        // 6: dead time of 2 -> out at phases 2..4, out_n at phases 7..9
        for (int i = 0; i < 20; i++) begin
            int ph;
            step();
            ph = i % 10;
            chk("t6.out", out, (ph >= 2) && (ph <= 4));
            chk("t6.out_n", out_n, ph >= 7);
            chk("t6.cs", cycle_start, ph == 0);
        end
`endif

        // 2: mid-period transfer of period 8 / duty 2
        cyc("t2.pre", 10, 5, 0, 3);
        send(16'd8, 16'd2);
        chk("t2.ready_before", cfg_ready, 1'b1);
        cyc("t2.xfer", 10, 5, 3, 1);
        cfg_valid = 1'b0;
        chk("t2.ready_drop", cfg_ready, 1'b0);
        cyc("t2.old", 10, 5, 4, 5);
        chk("t2.ready_held", cfg_ready, 1'b0);
        cyc("t2.wrap", 10, 5, 9, 1);
        chk("t2.ready_back", cfg_ready, 1'b1);
        cyc("t2.new", 8, 2, 0, 16);

        // 3a: duty 0
        send(16'd10, 16'd0);
        cyc("t3a.xfer", 8, 2, 0, 1);
        cfg_valid = 1'b0;
        cyc("t3a.old", 8, 2, 1, 7);
        cyc("t3a.new", 10, 0, 0, 20);

        // 3b: duty 12 over period 10
        send(16'd10, 16'd12);
        cyc("t3b.xfer", 10, 0, 0, 1);
        cfg_valid = 1'b0;
        cyc("t3b.old", 10, 0, 1, 9);
        cyc("t3b.new", 10, 12, 0, 20);

        // 3c: period 0 stored as 1
        send(16'd0, 16'd1);
        cyc("t3c.xfer", 10, 12, 0, 1);
        cfg_valid = 1'b0;
        cyc("t3c.old", 10, 12, 1, 9);
        cyc("t3c.new", 1, 1, 0, 10);
        chk("t3c.ready", cfg_ready, 1'b1);

        // 4: reset at cnt 6 with a pending config
        send(16'd10, 16'd5);
        cyc("t4.xfer", 1, 1, 0, 1);
        cfg_valid = 1'b0;
        chk("t4.ready_pend", cfg_ready, 1'b0);
        cyc("t4.apply", 1, 1, 0, 1);
        chk("t4.ready_free", cfg_ready, 1'b1);
        cyc("t4.run", 10, 5, 0, 5);
        send(16'd8, 16'd2);
        cyc("t4.xfer2", 10, 5, 5, 1);
        cfg_valid = 1'b0;
        chk("t4.ready_pend2", cfg_ready, 1'b0);
        emu_rst = 1'b1;
        step();
        chk("t4.rst.out", out, 1'b0);
        chk("t4.rst.out_n", out_n, 1'b0);
        chk("t4.rst.cs", cycle_start, 1'b0);
        chk("t4.rst.ready", cfg_ready, 1'b1);
        emu_rst = 1'b0;
        step();
        chk("t4.enter.out", out, 1'b0);
        chk("t4.enter.cs", cycle_start, 1'b0);
        cyc("t4.dflt", 10, 5, 0, 20);

        // 5: drop en at cnt 3, load a config while idle, re-enable
        cyc("t5.pre", 10, 5, 0, 3);
        en = 1'b0;
        step();
        chk("t5.off.out", out, 1'b0);
        chk("t5.off.out_n", out_n, 1'b0);
        chk("t5.off.cs", cycle_start, 1'b0);
        send(16'd10, 16'd4);
        step();
        chk("t5.idle_xfer.ready", cfg_ready, 1'b0);
        chk("t5.idle_xfer.out", out, 1'b0);
        cfg_valid = 1'b0;
        step();
        chk("t5.idle_apply.ready", cfg_ready, 1'b1);
        en = 1'b1;
        step();
        chk("t5.enter.out", out, 1'b0);
        cyc("t5.rerun", 10, 4, 0, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
